// File: rtl/mem_wb_stage_pkg.sv
// Shared RV32I opcode header for the memory/writeback stage: opcode and funct3
// constants plus the tohost CSR address and the pipeline NOP encoding.
package mem_wb_stage_pkg;

    localparam int          XLEN       = 32;
    localparam logic [11:0] CSR_TOHOST = 12'h51E;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FNC_B      = 3'b000;
    localparam logic [2:0] FNC_H      = 3'b001;
    localparam logic [2:0] FNC_W      = 3'b010;
    localparam logic [2:0] FNC_BU     = 3'b100;
    localparam logic [2:0] FNC_HU     = 3'b101;
    localparam logic [2:0] FNC_CSRRW  = 3'b001;
    localparam logic [2:0] FNC_CSRRWI = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Load data alignment: picks the addressed byte/halfword out of the returned
// cache word and sign- or zero-extends it according to funct3.
module load_extract
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{addr, 3'b000} +: 8];
        sel_half = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            FNC_B:   value = {{24{sel_byte[7]}}, sel_byte};
            FNC_BU:  value = {24'd0, sel_byte};
            FNC_H:   value = {{16{sel_half[15]}}, sel_half};
            FNC_HU:  value = {16'd0, sel_half};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage of the 3-stage RV32I pipeline: stage register, data
// cache handshake FSM, store formatting, tohost CSR and register-file write.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int          XLEN       = mem_wb_stage_pkg::XLEN,
    parameter logic [11:0] CSR_TOHOST = mem_wb_stage_pkg::CSR_TOHOST,
    parameter logic [31:0] NOP_INST   = mem_wb_stage_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            x_valid,
    input  logic [31:0]     x_inst,
    input  logic [XLEN-1:0] x_alu_out,
    input  logic [XLEN-1:0] x_rs2_data,
    input  logic [XLEN-1:0] x_pc_plus4,
    output logic            stall,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic            dc_req_write,
    output logic [XLEN-1:0] dc_req_addr,
    output logic [XLEN-1:0] dc_req_wdata,
    output logic [3:0]      dc_req_wmask,
    input  logic            dc_resp_valid,
    input  logic [XLEN-1:0] dc_resp_data,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     wb_inst,
    output logic [XLEN-1:0] csr_tohost
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      state;
    logic [31:0]     s_inst;
    logic [XLEN-1:0] s_alu;
    logic [XLEN-1:0] s_rs2;
    logic [XLEN-1:0] s_pc4;
    logic            s_valid;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            is_tohost_write;
    logic [XLEN-1:0] load_value;

    assign opcode   = s_inst[6:0];
    assign funct3   = s_inst[14:12];
    assign wb_rd    = s_inst[11:7];
    assign wb_inst  = s_inst;
    assign is_load  = s_valid && (opcode == OPC_LOAD);
    assign is_store = s_valid && (opcode == OPC_STORE);
    assign is_mem   = is_load || is_store;
    assign is_tohost_write = s_valid && (opcode == OPC_SYSTEM)
                          && ((funct3 == FNC_CSRRW) || (funct3 == FNC_CSRRWI))
                          && (s_inst[31:20] == CSR_TOHOST);

    // A captured memory op parks in IDLE for one cycle before requesting, so
    // upstream must already be frozen there or the op would be overwritten.
    always_comb begin
        case (state)
            S_IDLE:  stall = is_mem;
            S_REQ:   stall = !(dc_req_ready && is_store);
            S_WAIT:  stall = !dc_resp_valid;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_inst  <= NOP_INST;
            s_valid <= 1'b0;
            s_alu   <= '0;
            s_rs2   <= '0;
            s_pc4   <= '0;
        end else if (!stall) begin
            s_inst  <= x_valid ? x_inst : NOP_INST;
            s_valid <= x_valid;
            s_alu   <= x_alu_out;
            s_rs2   <= x_rs2_data;
            s_pc4   <= x_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (is_mem) state <= S_REQ;
                S_REQ:  if (dc_req_ready) state <= is_store ? S_IDLE : S_WAIT;
                S_WAIT: if (dc_resp_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_tohost <= '0;
        end else if ((state == S_IDLE) && is_tohost_write) begin
            csr_tohost <= s_alu;
        end
    end

    // Request fields come straight from the held stage register, which keeps
    // them stable until the handshake without extra capture registers.
    always_comb begin
        dc_req_valid = 1'b0;
        dc_req_write = 1'b0;
        dc_req_addr  = '0;
        dc_req_wdata = '0;
        dc_req_wmask = 4'b0000;
        if (state == S_REQ) begin
            dc_req_valid = 1'b1;
            dc_req_write = is_store;
            dc_req_addr  = {s_alu[XLEN-1:2], 2'b00};
            if (is_store) begin
                case (funct3)
                    FNC_B: begin
                        dc_req_wmask = 4'b0001 << s_alu[1:0];
                        dc_req_wdata = {4{s_rs2[7:0]}};
                    end
                    FNC_H: begin
                        dc_req_wmask = s_alu[1] ? 4'b1100 : 4'b0011;
                        dc_req_wdata = {2{s_rs2[15:0]}};
                    end
                    default: begin
                        dc_req_wmask = 4'b1111;
                        dc_req_wdata = s_rs2;
                    end
                endcase
            end
        end
    end

    load_extract u_load_extract (
        .funct3 (funct3),
        .addr   (s_alu[1:0]),
        .word   (dc_resp_data),
        .value  (load_value)
    );

    always_comb begin
        wb_en   = 1'b0;
        wb_data = s_alu;
        if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
            wb_data = s_pc4;
        end else if (opcode == OPC_LOAD) begin
            wb_data = load_value;
        end
        case (state)
            S_IDLE: begin
                if (s_valid && (wb_rd != 5'd0)) begin
                    case (opcode)
                        OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM,
                        OPC_JAL, OPC_JALR: wb_en = 1'b1;
                        default:           wb_en = 1'b0;
                    endcase
                end
            end
            S_WAIT:  wb_en = dc_resp_valid && (wb_rd != 5'd0);
            default: wb_en = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// instruction traffic checked against a transaction-level reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [31:0] x_inst = 32'h0000_0013;
    logic [31:0] x_alu_out = '0;
    logic [31:0] x_rs2_data = '0;
    logic [31:0] x_pc_plus4 = '0;
    logic        stall;
    logic        dc_req_valid;
    logic        dc_req_ready = 1'b0;
    logic        dc_req_write;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic [3:0]  dc_req_wmask;
    logic        dc_resp_valid = 1'b0;
    logic [31:0] dc_resp_data = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_inst;
    logic [31:0] csr_tohost;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_tohost = '0;
    logic [31:0] f_inst;
    logic [31:0] f_alu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    mem_wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .x_valid       (x_valid),
        .x_inst        (x_inst),
        .x_alu_out     (x_alu_out),
        .x_rs2_data    (x_rs2_data),
        .x_pc_plus4    (x_pc_plus4),
        .stall         (stall),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_write  (dc_req_write),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_wmask  (dc_req_wmask),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_data  (dc_resp_data),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_inst       (wb_inst),
        .csr_tohost    (csr_tohost)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected architectural effects from instruction fields.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] modelMask(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3 == 3'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic void modelRetire(input logic [31:0] inst, input logic [31:0] alu,
                                        input logic [31:0] pc4, output logic en,
                                        output logic [31:0] data);
        logic [6:0] opc;
        opc  = inst[6:0];
        en   = 1'b0;
        data = alu;
        if (opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b0110011 || opc == 7'b0010011)
            en = (inst[11:7] != 0);
        if (opc == 7'b1101111 || opc == 7'b1100111) begin
            en   = (inst[11:7] != 0);
            data = pc4;
        end
    endfunction

    task automatic driveFollower();
        logic [31:0] r;
        r       = $urandom;
        f_inst  = {r[31:12], r[11:7], 7'b0010011};
        f_inst[14:12] = 3'b000;
        f_alu   = $urandom;
        x_valid = 1'b1;
        x_inst  = f_inst;
        x_alu_out  = f_alu;
        x_rs2_data = $urandom;
        x_pc_plus4 = $urandom;
    endtask

    task automatic checkBubble();
        x_valid = 1'b0;
        x_inst  = $urandom;
        @(negedge clk);
        checkOutput("tohost", csr_tohost, model_tohost);
        checkOutput("bubble_inst", wb_inst, NOP);
        checkOutput("bubble_wb_en", {31'd0, wb_en}, 32'd0);
    endtask

    // Called at a negedge; returns at a negedge with the stage idle.
    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [31:0] pc4,
                                 input logic [31:0] resp_word, input int ready_lo,
                                 input int resp_wait);
        logic        is_load;
        logic        is_store;
        logic        en;
        logic [31:0] data;
        logic        rdy;
        logic        done;
        is_load  = (inst[6:0] == 7'b0000011);
        is_store = (inst[6:0] == 7'b0100011);
        x_valid = 1'b1;
        x_inst = inst;
        x_alu_out = alu;
        x_rs2_data = rs2;
        x_pc_plus4 = pc4;
        @(negedge clk);
        checkOutput("wb_inst", wb_inst, inst);
        if (!is_load && !is_store) begin
            modelRetire(inst, alu, pc4, en, data);
            checkOutput("stall_alu", {31'd0, stall}, 32'd0);
            checkOutput("wb_en", {31'd0, wb_en}, {31'd0, en});
            if (en) begin
                checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, inst[11:7]});
                checkOutput("wb_data", wb_data, data);
            end
            if (inst[6:0] == 7'b1110011 && inst[31:20] == 12'h51E &&
                (inst[14:12] == 3'd1 || inst[14:12] == 3'd5))
                model_tohost = alu;
            checkBubble();
            return;
        end
        checkOutput("stall_idle", {31'd0, stall}, 32'd1);
        checkOutput("req_early", {31'd0, dc_req_valid}, 32'd0);
        checkOutput("wb_en_mem", {31'd0, wb_en}, 32'd0);
        driveFollower();
        @(negedge clk);
        done = 1'b0;
        for (int cyc = 0; cyc < 32 && !done; cyc++) begin
            checkOutput("req_valid", {31'd0, dc_req_valid}, 32'd1);
            checkOutput("req_write", {31'd0, dc_req_write}, {31'd0, is_store});
            checkOutput("req_addr", dc_req_addr, alu & 32'hFFFF_FFFC);
            if (is_store) begin
                checkOutput("req_wmask", {28'd0, dc_req_wmask},
                            {28'd0, modelMask(inst[14:12], alu[1:0])});
                checkOutput("req_wdata", dc_req_wdata, modelWdata(inst[14:12], rs2));
            end
            checkOutput("req_wb_inst", wb_inst, inst);
            checkOutput("req_wb_en", {31'd0, wb_en}, 32'd0);
            rdy = (cyc >= ready_lo);
            dc_req_ready = rdy;
            driveFollower();
            #1;
            checkOutput("stall_req", {31'd0, stall}, {31'd0, !(rdy && is_store)});
            @(negedge clk);
            done = rdy;
        end
        dc_req_ready = 1'b0;
        if (!done) checkOutput("req_timeout", 32'd0, 32'd1);
        if (is_load) begin
            for (int cyc = 0; cyc <= resp_wait; cyc++) begin
                checkOutput("wait_req_valid", {31'd0, dc_req_valid}, 32'd0);
                checkOutput("wait_wb_inst", wb_inst, inst);
                dc_resp_valid = (cyc == resp_wait);
                dc_resp_data  = (cyc == resp_wait) ? resp_word : $urandom;
                driveFollower();
                #1;
                checkOutput("stall_wait", {31'd0, stall}, {31'd0, cyc != resp_wait});
                if (cyc == resp_wait) begin
                    checkOutput("load_wb_en", {31'd0, wb_en}, {31'd0, inst[11:7] != 0});
                    if (inst[11:7] != 0) begin
                        checkOutput("load_wb_rd", {27'd0, wb_rd}, {27'd0, inst[11:7]});
                        checkOutput("load_data", wb_data,
                                    modelLoad(inst[14:12], alu[1:0], resp_word));
                    end
                end else begin
                    checkOutput("wait_wb_en", {31'd0, wb_en}, 32'd0);
                end
                @(negedge clk);
            end
            dc_resp_valid = 1'b0;
        end
        checkOutput("follow_inst", wb_inst, f_inst);
        checkOutput("follow_stall", {31'd0, stall}, 32'd0);
        checkOutput("follow_wb_en", {31'd0, wb_en}, {31'd0, f_inst[11:7] != 0});
        if (f_inst[11:7] != 0) checkOutput("follow_data", wb_data, f_alu);
        checkBubble();
    endtask

    task automatic runRandom(input int count);
        logic [31:0] r;
        logic [31:0] inst;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [11:0] csr;
        int          kind;
        for (int n = 0; n < count; n++) begin
            r    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            f3   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            case (kind)
                0: inst = {r[31:15], f3, rd, 7'b0010011};
                1: inst = {r[31:15], f3, rd, 7'b0110011};
                2: inst = {r[31:15], f3, rd, 7'b0110111};
                3: inst = {r[31:15], f3, rd, 7'b0010111};
                4: inst = {r[31:15], f3, rd, 7'b1101111};
                5: inst = {r[31:15], 3'b000, rd, 7'b1100111};
                6: inst = {r[31:15], f3, rd, 7'b1100011};
                7: begin
                    csr = ($urandom_range(0, 2) == 0) ? 12'h51F : 12'h51E;
                    case ($urandom_range(0, 2))
                        0:       f3 = 3'd1;
                        1:       f3 = 3'd5;
                        default: f3 = 3'd2;
                    endcase
                    inst = {csr, r[19:15], f3, rd, 7'b1110011};
                end
                8: begin
                    case ($urandom_range(0, 4))
                        0:       f3 = 3'd0;
                        1:       f3 = 3'd1;
                        2:       f3 = 3'd2;
                        3:       f3 = 3'd4;
                        default: f3 = 3'd5;
                    endcase
                    inst = {r[31:15], f3, rd, 7'b0000011};
                end
                default: begin
                    f3   = 3'($urandom_range(0, 2));
                    inst = {r[31:15], f3, rd, 7'b0100011};
                end
            endcase
            applyStimulus(inst, $urandom, $urandom, $urandom, $urandom,
                          $urandom_range(0, 4), $urandom_range(0, 4));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_req_valid", {31'd0, dc_req_valid}, 32'd0);
        checkOutput("rst_req_write", {31'd0, dc_req_write}, 32'd0);
        checkOutput("rst_req_addr", dc_req_addr, 32'd0);
        checkOutput("rst_req_wdata", dc_req_wdata, 32'd0);
        checkOutput("rst_req_wmask", {28'd0, dc_req_wmask}, 32'd0);
        checkOutput("rst_wb_en", {31'd0, wb_en}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_wb_inst", wb_inst, NOP);
        checkOutput("rst_tohost", csr_tohost, 32'd0);
        reset = 1'b0;

        applyStimulus(32'h0070_0293, 32'd7, 32'h1234_5678, 32'h44, 32'd0, 0, 0);
        applyStimulus({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0100011}, 32'h1003, 32'hAB,
                      32'h0, 32'd0, 0, 0);
        applyStimulus({12'd0, 5'd1, 3'b000, 5'd6, 7'b0000011}, 32'h2002, 32'h0,
                      32'h0, 32'h0080_0000, 0, 3);
        applyStimulus({12'd0, 5'd1, 3'b100, 5'd6, 7'b0000011}, 32'h2002, 32'h0,
                      32'h0, 32'h0080_0000, 0, 3);
        applyStimulus({12'd0, 5'd1, 3'b001, 5'd7, 7'b0000011}, 32'h10, 32'h0,
                      32'h0, 32'hCAFE_9ABC, 4, 1);
        applyStimulus({12'h51E, 5'd1, 3'b001, 5'd0, 7'b1110011}, 32'd1, 32'h0,
                      32'h0, 32'd0, 0, 0);
        applyStimulus({12'h51F, 5'd1, 3'b001, 5'd0, 7'b1110011}, 32'd5, 32'h0,
                      32'h0, 32'd0, 0, 0);
        applyStimulus({20'h12345, 5'd9, 7'b1101111}, 32'h0, 32'h0,
                      32'h0000_1008, 32'd0, 0, 0);

        runRandom(150);

        // Reset arriving while a load waits for its response.
        applyStimulus({12'h51E, 5'd3, 3'b101, 5'd0, 7'b1110011}, 32'hDEAD_BEEF, 32'h0,
                      32'h0, 32'd0, 0, 0);
        x_valid = 1'b1;
        x_inst  = {12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011};
        x_alu_out = 32'h300;
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0;
        checkOutput("pre_rst_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        model_tohost = 32'd0;
        checkOutput("midrst_req_valid", {31'd0, dc_req_valid}, 32'd0);
        checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
        checkOutput("midrst_wb_inst", wb_inst, NOP);
        checkOutput("midrst_tohost", csr_tohost, 32'd0);
        reset = 1'b0;
        applyStimulus(32'h0070_0293, 32'd42, 32'h0, 32'h0, 32'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
